// File: rtl/bufmem_pkg.sv
// Shared definitions for the packet-buffer ownership arbiter.
//   - buffer mode-select encodings driven on adr_mode_o
//   - arbiter state encoding
//   - default guard length used on every clock-source change
package bufmem_pkg;

  // Buffer address/clock mode select.
  localparam logic [1:0] MODE_BUS = 2'b00;
  localparam logic [1:0] MODE_DMA = 2'b01;
  localparam logic [1:0] MODE_ETH = 2'b10;

  // Dead cycles around any switch into or out of the ETH clock.
  localparam int unsigned GUARD_CYC_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StGrantBus,
    StGrantDma,
    StGrantEth,
    StGuard
  } arb_state_e;

endpackage

// File: rtl/bufmem_arbiter.sv
// Ownership arbiter for one shared packet buffer (RX or TX).
//
// Three requesters share the buffer: Wishbone bus, DMA engine and Ethernet MAC.
// Priority in IDLE is fixed ETH > DMA > BUS; a grant is held for as long as its
// request stays high. Any move into or out of ETH ownership passes through
// GUARD_CYC dead cycles so the buffer clock mux settles before a write.
//
// Ports:
//   wb_clk_i, wb_rst_n_i  clock and asynchronous active-low reset
//   bus_req_i/bus_gnt_o   bus tenure; buf_stb_o = bus_req_i & bus_gnt_o
//   dma_req_i/dma_gnt_o   DMA tenure
//   eth_req_i/eth_gnt_o   MAC tenure (request pre-synchronised to wb_clk_i)
//   adr_mode_o            00 bus/idle, 01 DMA, 10 ETH
//   busy_o                high in every state except IDLE
//   tmo_o, tmo_clr_i      sticky watchdog flag and its clear
//
// Optional feature: define BUFARB_WATCHDOG_EN to bound a tenure at MAX_HOLD
// cycles whenever another requester is waiting. Without it tmo_o is 0 and
// tmo_clr_i is ignored.
module bufmem_arbiter
  import bufmem_pkg::*;
#(
  parameter int unsigned GUARD_CYC = GUARD_CYC_DEF,
  parameter int unsigned MAX_HOLD  = 1024,
  parameter int unsigned HOLD_W    = 11
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       bus_req_i,
  output logic       bus_gnt_o,
  output logic       buf_stb_o,
  input  logic       dma_req_i,
  output logic       dma_gnt_o,
  input  logic       eth_req_i,
  output logic       eth_gnt_o,
  output logic [1:0] adr_mode_o,
  output logic       busy_o,
  output logic       tmo_o,
  input  logic       tmo_clr_i
);

  // Guard counter runs GuardLoad..0, i.e. GUARD_CYC cycles in StGuard.
  localparam logic [2:0] GuardLoad = 3'(GUARD_CYC - 1);

  arb_state_e state_q, state_d;
  logic       bus_gnt_q, bus_gnt_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       eth_gnt_q, eth_gnt_d;
  logic [1:0] mode_q, mode_d;
  logic       busy_q, busy_d;
  logic [2:0] guard_q, guard_d;
  // Set while the guard leads into ETH, clear while it leads out.
  logic       to_eth_q, to_eth_d;
  logic       wd_fire;
  logic       arb_go;

`ifdef BUFARB_WATCHDOG_EN
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tmo_q, tmo_d;
  logic              own_req, other_pend, in_grant;

  assign in_grant   = bus_gnt_q | dma_gnt_q | eth_gnt_q;
  assign own_req    = (bus_req_i & bus_gnt_q) | (dma_req_i & dma_gnt_q) | (eth_req_i & eth_gnt_q);
  assign other_pend = (bus_req_i & ~bus_gnt_q) | (dma_req_i & ~dma_gnt_q) |
                      (eth_req_i & ~eth_gnt_q);
  // Only a tenure that would otherwise continue is cut short.
  assign wd_fire    = own_req & other_pend & (hold_q == HoldLast);

  always_comb begin
    hold_d = '0;
    if (in_grant) begin
      // Saturate so a late competing request forces release at once.
      hold_d = (hold_q == HoldLast) ? hold_q : hold_q + 1'b1;
    end
  end

  // Set wins over a same-cycle clear.
  assign tmo_d = wd_fire | (tmo_q & ~tmo_clr_i);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      hold_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_o = tmo_q;
`else
  logic [HOLD_W-1:0] unused_hold;
  logic              unused_tmo_clr;

  assign unused_hold    = HOLD_W'(MAX_HOLD);
  assign unused_tmo_clr = tmo_clr_i;
  assign wd_fire        = 1'b0;
  assign tmo_o          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bus_gnt_d = bus_gnt_q;
    dma_gnt_d = dma_gnt_q;
    eth_gnt_d = eth_gnt_q;
    mode_d    = mode_q;
    guard_d   = guard_q;
    to_eth_d  = to_eth_q;
    arb_go    = 1'b0;

    unique case (state_q)
      StIdle: arb_go = 1'b1;

      StGuard: begin
        if (guard_q != 3'd0) begin
          guard_d = guard_q - 3'd1;
        end else if (to_eth_q && eth_req_i) begin
          state_d   = StGrantEth;
          eth_gnt_d = 1'b1;
        end else if (to_eth_q) begin
          // MAC withdrew during lead-in; the mux already moved to ETH, so guard back out.
          guard_d  = GuardLoad;
          to_eth_d = 1'b0;
          mode_d   = MODE_BUS;
        end else begin
          // Requests held during the guard are arbitrated on its final edge.
          arb_go = 1'b1;
        end
      end

      StGrantBus: begin
        if (!bus_req_i || wd_fire) begin
          state_d   = StIdle;
          bus_gnt_d = 1'b0;
          mode_d    = MODE_BUS;
        end
      end

      StGrantDma: begin
        if (!dma_req_i || wd_fire) begin
          state_d   = StIdle;
          dma_gnt_d = 1'b0;
          mode_d    = MODE_BUS;
        end
      end

      StGrantEth: begin
        if (!eth_req_i || wd_fire) begin
          state_d   = StGuard;
          eth_gnt_d = 1'b0;
          mode_d    = MODE_BUS;
          guard_d   = GuardLoad;
          to_eth_d  = 1'b0;
        end
      end

      default: begin
        state_d   = StIdle;
        bus_gnt_d = 1'b0;
        dma_gnt_d = 1'b0;
        eth_gnt_d = 1'b0;
        mode_d    = MODE_BUS;
      end
    endcase

    if (arb_go) begin
      if (eth_req_i) begin
        // Switch the clock source first; the grant follows after the guard.
        state_d  = StGuard;
        mode_d   = MODE_ETH;
        guard_d  = GuardLoad;
        to_eth_d = 1'b1;
      end else if (dma_req_i) begin
        state_d   = StGrantDma;
        mode_d    = MODE_DMA;
        dma_gnt_d = 1'b1;
      end else if (bus_req_i) begin
        state_d   = StGrantBus;
        mode_d    = MODE_BUS;
        bus_gnt_d = 1'b1;
      end else begin
        state_d = StIdle;
        mode_d  = MODE_BUS;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= StIdle;
      bus_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      eth_gnt_q <= 1'b0;
      mode_q    <= MODE_BUS;
      busy_q    <= 1'b0;
      guard_q   <= 3'd0;
      to_eth_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_gnt_q <= bus_gnt_d;
      dma_gnt_q <= dma_gnt_d;
      eth_gnt_q <= eth_gnt_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      guard_q   <= guard_d;
      to_eth_q  <= to_eth_d;
    end
  end

  assign bus_gnt_o  = bus_gnt_q;
  assign dma_gnt_o  = dma_gnt_q;
  assign eth_gnt_o  = eth_gnt_q;
  assign adr_mode_o = mode_q;
  assign busy_o     = busy_q;
  // Bus cycles stall outside a bus tenure because the buffer never sees a strobe.
  assign buf_stb_o  = bus_req_i & bus_gnt_q;

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Randomised, scoreboarded bench for bufmem_arbiter.
// Stimulus is applied on the falling edge; a behavioural model computes the
// outputs expected after the next rising edge and queues them; a monitor pops
// one entry per rising edge and compares.
module tb_bufmem_arbiter;

  localparam int unsigned Guard   = 2;
  localparam int unsigned MaxHold = 16;
`ifdef BUFARB_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       bus_req, dma_req, eth_req, tmo_clr;
  logic       bus_gnt, dma_gnt, eth_gnt, buf_stb, busy, tmo;
  logic [1:0] adr_mode;

  bufmem_arbiter #(
    .GUARD_CYC(Guard),
    .MAX_HOLD (MaxHold),
    .HOLD_W   (5)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus_req_i (bus_req),
    .bus_gnt_o (bus_gnt),
    .buf_stb_o (buf_stb),
    .dma_req_i (dma_req),
    .dma_gnt_o (dma_gnt),
    .eth_req_i (eth_req),
    .eth_gnt_o (eth_gnt),
    .adr_mode_o(adr_mode),
    .busy_o    (busy),
    .tmo_o     (tmo),
    .tmo_clr_i (tmo_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       bus;
    logic       dma;
    logic       eth;
    logic [1:0] mode;
    logic       busy;
    logic       tmo;
    logic       stb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the buffer, how many guard cycles remain, and
  // whether the guard leads into ETH.
  int owner;      // 0 none, 1 bus, 2 dma, 3 eth
  int guard_left; // 0 when not guarding
  bit guard_eth;
  int mode;
  int held;       // cycles the current owner has held the buffer
  bit m_tmo;

  function automatic void model_reset();
    owner = 0; guard_left = 0; guard_eth = 0; mode = 0; held = 0; m_tmo = 0;
  endfunction

  function automatic void arbitrate(input bit b, input bit d, input bit e);
    if (e) begin
      guard_left = Guard; guard_eth = 1; mode = 2;
    end else if (d) begin
      owner = 2; mode = 1; held = 1;
    end else if (b) begin
      owner = 1; mode = 0; held = 1;
    end else begin
      mode = 0;
    end
  endfunction

  function automatic void release_owner();
    if (owner == 3) begin
      guard_left = Guard; guard_eth = 0;
    end
    owner = 0; mode = 0;
  endfunction

  function automatic void model_step(input bit b, input bit d, input bit e, input bit clr);
    bit set_tmo = 0;
    bit own_req, pend;
    if (guard_left > 0) begin
      guard_left--;
      if (guard_left == 0) begin
        if (guard_eth && e) begin
          owner = 3; held = 1;
        end else if (guard_eth) begin
          guard_left = Guard; guard_eth = 0; mode = 0;
        end else begin
          arbitrate(b, d, e);
        end
      end
    end else if (owner != 0) begin
      own_req = (owner == 1) ? b : (owner == 2) ? d : e;
      pend = (b && owner != 1) || (d && owner != 2) || (e && owner != 3);
      if (!own_req) begin
        release_owner();
      end else if (WdEn && held >= MaxHold && pend) begin
        release_owner();
        set_tmo = 1;
      end else begin
        held++;
      end
    end else begin
      arbitrate(b, d, e);
    end
    m_tmo = set_tmo | (m_tmo & ~clr);
  endfunction

  task automatic drive(input bit b, input bit d, input bit e, input bit clr);
    exp_t x;
    @(negedge clk);
    bus_req = b; dma_req = d; eth_req = e; tmo_clr = clr;
    model_step(b, d, e, clr);
    x.bus  = (owner == 1);
    x.dma  = (owner == 2);
    x.eth  = (owner == 3);
    x.mode = 2'(mode);
    x.busy = (owner != 0) || (guard_left > 0);
    x.tmo  = m_tmo;
    x.stb  = b && (owner == 1);
    sb.push_back(x);
  endtask

  task automatic hold(input int n, input bit b, input bit d, input bit e);
    for (int i = 0; i < n; i++) drive(b, d, e, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {29'd0, bus_gnt, dma_gnt, eth_gnt}, 32'd0);
    check({tag, "_mode"}, {30'd0, adr_mode}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tmo"}, {31'd0, tmo}, 32'd0);
  endtask

  // Reset between clock edges; outputs must clear without a clock edge.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_reset_outputs("rst_async");
    bus_req = 0; dma_req = 0; eth_req = 0; tmo_clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("bus_gnt", {31'd0, bus_gnt}, {31'd0, e.bus});
      check("dma_gnt", {31'd0, dma_gnt}, {31'd0, e.dma});
      check("eth_gnt", {31'd0, eth_gnt}, {31'd0, e.eth});
      check("adr_mode", {30'd0, adr_mode}, {30'd0, e.mode});
      check("busy", {31'd0, busy}, {31'd0, e.busy});
      check("tmo", {31'd0, tmo}, {31'd0, e.tmo});
      check("buf_stb", {31'd0, buf_stb}, {31'd0, e.stb});
    end
  end

  initial begin
    bit rb, rd, re;
    rst_n = 1'b0;
    bus_req = 0; dma_req = 0; eth_req = 0; tmo_clr = 0;
    model_reset();
    #3;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Bus alone: one-cycle grant latency, strobe follows request, release to idle.
    hold(5, 1, 0, 0);
    hold(3, 0, 0, 0);

    // All rise together: ETH after guard, then guard out, then DMA; bus waits.
    hold(12, 1, 1, 1);
    hold(8, 1, 1, 0);
    hold(5, 1, 0, 0);
    hold(3, 0, 0, 0);

    // DMA owns while bus waits: no strobe, bus granted two edges after release.
    hold(3, 0, 1, 0);
    hold(4, 1, 1, 0);
    hold(5, 1, 0, 0);
    hold(3, 0, 0, 0);

    // MAC withdraws during the lead-in guard.
    hold(1, 0, 0, 1);
    hold(6, 0, 0, 0);

    // Long DMA tenure with bus pending, then clear pulse, then DMA alone.
    hold(20, 0, 1, 0);
    hold(22, 1, 1, 0);
    hold(3, 0, 0, 0);
    drive(0, 0, 0, 1);
    hold(2, 0, 0, 0);
    hold(100, 0, 1, 0);
    hold(3, 0, 0, 0);

    // Reset mid ETH tenure.
    hold(6, 0, 0, 1);
    reset_mid();
    hold(4, 0, 0, 0);

    // Random level requests with occasional resets.
    rb = 0; rd = 0; re = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      if ($urandom_range(0, 9) == 0) rd = ~rd;
      if ($urandom_range(0, 15) == 0) re = ~re;
      drive(rb, rd, re, ($urandom_range(0, 15) == 0));
      if (i == 1000 || i == 2200) begin
        reset_mid();
        rb = 0; rd = 0; re = 0;
      end
    end

    hold(3, 0, 0, 0);
    @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
